// File: rtl/bidir_counter_monitor_if.sv
// Observation/status bundle between a bidirectional 0..MAX_VAL counter and its monitor.
// Optional SEG7_OUT_EN adds the seven-segment view of the last sample.
interface bidir_counter_monitor_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic [3:0]       q;
    logic             locked;
    logic             dir;
    logic [3:0]       q_last;
    logic             err;
    logic [CNT_W-1:0] turn_count;
    logic [CNT_W-1:0] err_count;
`ifdef SEG7_OUT_EN
    logic [6:0]       seg;

    modport master (output enable, q,
                    input  locked, dir, q_last, err, turn_count, err_count, seg);
    modport slave  (input  enable, q,
                    output locked, dir, q_last, err, turn_count, err_count, seg);
`else
    modport master (output enable, q,
                    input  locked, dir, q_last, err, turn_count, err_count);
    modport slave  (input  enable, q,
                    output locked, dir, q_last, err, turn_count, err_count);
`endif
endinterface

// File: rtl/bidir_counter_monitor.sv
// Receive-side checker for an up/down bouncing 0..MAX_VAL counter stream.
// Define SEG7_OUT_EN to add a registered active-low seven-segment decode of q_last.
//
// state   | meaning
// SYNC    | waiting for the first in-range sample
// ACQ     | counting consecutive legal steps towards lock
// LOCK_UP | locked, expecting the counter to rise
// LOCK_DN | locked, expecting the counter to fall
// ERR     | just saw a violation while locked; next sample restarts acquisition
module bidir_counter_monitor #(
    parameter int MAX_VAL  = 9,
    parameter int LOCK_LEN = 2,
    parameter int CNT_W    = 8
) (
    input logic clki,
    input logic reset,
    bidir_counter_monitor_if.slave bus
);
    typedef enum logic [2:0] {SYNC, ACQ, LOCK_UP, LOCK_DN, ERR} state_t;

    localparam logic [3:0] MAXV  = 4'(MAX_VAL);
    localparam logic [2:0] LOCKV = 3'(LOCK_LEN);

    state_t           state;
    logic [2:0]       acq_cnt;
    logic             acq_dir;
    logic             locked_r, dir_r, err_r;
    logic [3:0]       q_last_r;
    logic [CNT_W-1:0] turn_r, errc_r;

    logic       q_ok, step_up, step_dn, legal, boundary;
    logic [2:0] acq_next;

    always_comb begin
        q_ok     = (bus.q <= MAXV);
        step_up  = q_ok && (q_last_r < MAXV) && (bus.q == q_last_r + 4'd1);
        step_dn  = q_ok && (q_last_r != 4'd0) && (bus.q == q_last_r - 4'd1);
        legal    = step_up || step_dn;
        // Bouncing off either end is the counter's normal behaviour, not a reversal
        boundary = ((q_last_r == MAXV) && step_dn) || ((q_last_r == 4'd0) && step_up);
        acq_next = 3'd1;
        if (state == ACQ && (acq_cnt == 3'd0 || step_up == acq_dir || boundary))
            acq_next = acq_cnt + 3'd1;
    end

    always_ff @(posedge clki or posedge reset) begin
        if (reset) begin
            state    <= SYNC;
            acq_cnt  <= 3'd0;
            acq_dir  <= 1'b1;
            locked_r <= 1'b0;
            dir_r    <= 1'b1;
            err_r    <= 1'b0;
            q_last_r <= 4'd0;
            turn_r   <= '0;
            errc_r   <= '0;
        end else begin
            err_r <= 1'b0;
            if (bus.enable) begin
                q_last_r <= bus.q;
                case (state)
                    SYNC: begin
                        if (q_ok) begin
                            state   <= ACQ;
                            acq_cnt <= 3'd0;
                        end
                    end
                    ACQ, ERR: begin
                        state <= ACQ;
                        if (!legal) begin
                            acq_cnt <= 3'd0;
                        end else begin
                            acq_dir <= step_up;
                            if (acq_next >= LOCKV) begin
                                state    <= step_up ? LOCK_UP : LOCK_DN;
                                locked_r <= 1'b1;
                                dir_r    <= step_up;
                                acq_cnt  <= 3'd0;
                            end else begin
                                acq_cnt <= acq_next;
                            end
                        end
                    end
                    LOCK_UP, LOCK_DN: begin
                        if (state == LOCK_UP && q_last_r != MAXV && step_up) begin
                            state <= LOCK_UP;
                        end else if (state == LOCK_UP && q_last_r == MAXV && step_dn) begin
                            state  <= LOCK_DN;
                            dir_r  <= 1'b0;
                            turn_r <= turn_r + 1'b1;
                        end else if (state == LOCK_DN && q_last_r != 4'd0 && step_dn) begin
                            state <= LOCK_DN;
                        end else if (state == LOCK_DN && q_last_r == 4'd0 && step_up) begin
                            state  <= LOCK_UP;
                            dir_r  <= 1'b1;
                            turn_r <= turn_r + 1'b1;
                        end else begin
                            state    <= ERR;
                            locked_r <= 1'b0;
                            err_r    <= 1'b1;
                            if (errc_r != '1)
                                errc_r <= errc_r + 1'b1;
                        end
                    end
                    default: state <= SYNC;
                endcase
            end
        end
    end

    assign bus.locked     = locked_r;
    assign bus.dir        = dir_r;
    assign bus.q_last     = q_last_r;
    assign bus.err        = err_r;
    assign bus.turn_count = turn_r;
    assign bus.err_count  = errc_r;

`ifdef SEG7_OUT_EN
    logic [6:0] seg_r;

    function automatic logic [6:0] seg_dec(input logic [3:0] v);
        case (v)
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = 7'b1111111;
        endcase
    endfunction

    // Decoded from the incoming sample so seg changes on the same edge as q_last
    always_ff @(posedge clki or posedge reset) begin
        if (reset)
            seg_r <= 7'b1000000;
        else if (bus.enable)
            seg_r <= seg_dec(bus.q);
    end

    assign bus.seg = seg_r;
`endif
endmodule
